pwr_trans_acc: RTL and testbench
================================

Name: pwr_trans_acc

Overview:
Synthesizable, parametrised successor to the per-gate simulation power counters. Monitors N_CH signal channels and detects 0->1 output transitions on each one. Each detected transition adds a per-channel power weight into a saturating per-channel accumulator and into a global total. Accumulators are read through a req/ack handshake, so power activity can be measured on silicon or in gate-level simulation without hierarchical references into the testbench.

Parameters:
N_CH, 4, number of monitored channels (>=2).
WW, 4, width of each channel's weight (power ponderation).
CW, 8, width of each per-channel accumulator.
TW, 12, width of the global total accumulator.
SW, 2, width of the read-select index; must be >= clog2(N_CH).
FALL_W, 1, fixed weight added per 1->0 transition (optional feature only).

Ports:
clk  in  1  single clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  1 = accumulate; 0 = freeze accumulators (edge tracking continues).
clr  in  1  synchronous clear of all accumulators, sat flags and total.
sig_in  in  N_CH  monitored signals, synchronous to clk.
weight_in  in  N_CH*WW  weight per channel; channel i uses bits [i*WW +: WW]; weight 0 masks the channel.
rd_req  in  1  read request (level).
rd_sel  in  SW  channel to read, sampled when the request is accepted.
rd_ack  out  1  read data valid.
rd_data  out  CW  captured channel accumulator.
rd_sat  out  1  captured sticky saturation flag of the selected channel.
total  out  TW  global weighted transition sum, saturating.
total_sat  out  1  sticky; set when total saturates.

Behaviour:
- Reset (reset=1 at a clk edge):
  - All accumulators, sat flags, total, total_sat, rd_ack, rd_data and rd_sat go to 0; FSM goes to IDLE.
  - prev[i] <= sig_in[i], so a signal held high through reset produces no spurious edge.
- Edge detect:
  - rise[i] = sig_in[i] & ~prev[i].
  - prev is updated every cycle regardless of enable or clr.
  - Latency: an edge that appears before clock edge k is reflected in the accumulator after edge k.
- Accumulate (enable=1, clr=0): cnt[i] <= min(cnt[i] + rise[i]*w[i], 2^CW-1).
  - sat[i] is set when the true sum exceeds 2^CW-1 and stays set until reset or clr.
  - total <= min(total + sum of rise[i]*w[i] over all i, 2^TW-1); total_sat behaves the same way.
  - Intermediate sums are computed at full width so no wrap-around can occur.
- Priority: reset > clr > accumulate.
  - clr in the same cycle as an edge: the result is 0 and that edge is lost.
  - enable=0: no accumulation, but edges are still consumed by prev.
- Read FSM:
  - IDLE: on rd_req=1, capture rd_data <= cnt[rd_sel] and rd_sat <= sat[rd_sel] (pre-increment register values), then go to ACK. rd_ack=1 from the next cycle.
  - ACK: hold rd_ack=1 and rd_data/rd_sat stable while rd_req=1. When rd_req=0, set rd_ack <= 0 and return to IDLE.
  - One capture per request; a new read requires rd_req to drop and then rise again.
  - rd_sel >= N_CH returns rd_data=0, rd_sat=0, with a normal ack.
  - clr while in ACK does not alter the held rd_data.
  - reset while in ACK drops rd_ack the next cycle.
- Accumulation continues during reads; the captured value is a snapshot.

Optional Feature:
PWR_FALL_EDGE_EN:
- Defined: fall[i] = ~sig_in[i] & prev[i], and each fall adds FALL_W (saturating) to cnt[i] and total.
  - A rise and a fall on the same channel in the same cycle cannot occur.
  - Masking by weight_in=0 also masks falls.
- Undefined: only rising transitions are counted and FALL_W is unused, matching the gate-library rule that power is consumed on 0->1 output transitions.

Test Plan:
1. N_CH=4: hold sig_in=4'b1111 through reset, then release and wait 5 cycles -> all cnt=0, total=0, rd_ack=0.
2. ch0 weight=5, three 0->1 pulses, then read ch0 -> rd_data=15, rd_sat=0, total=15; rd_ack stays 1 until rd_req drops.
3. ch1 weight=15, 20 rises -> rd_data=255, rd_sat=1, total=300, total_sat=0.
4. ch2 cnt=7, weight=2, rise arriving in the same cycle as the IDLE capture of ch2 -> rd_data=7; next read returns 9.
5. clr in the same cycle as a rise on ch3 (weight 4) -> ch3 cnt=0, total=0, sat flags=0; a subsequent rise gives cnt=4.
6. PWR_FALL_EDGE_EN defined, FALL_W=1, ch0 weight=3, two full pulses -> ch0 cnt=8; macro undefined -> cnt=6.

Source files
------------

// File: rtl/pwr_trans_acc.sv
// pwr_trans_acc: transition-weighted power accumulator.
// Watches N_CH synchronous signals and detects 0->1 transitions. Each
// transition adds that channel's weight into a saturating per-channel
// accumulator and into a saturating global total. A req/ack handshake
// returns a snapshot of one channel's accumulator and sticky sat flag.
// Optional build macro PWR_FALL_EDGE_EN: 1->0 transitions also add FALL_W
// to unmasked channels.
module pwr_trans_acc #(
  parameter int N_CH   = 4,
  parameter int WW     = 4,
  parameter int CW     = 8,
  parameter int TW     = 12,
  parameter int SW     = 2,
  parameter int FALL_W = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clr,
  input  logic [N_CH-1:0]    sig_in,
  input  logic [N_CH*WW-1:0] weight_in,
  input  logic               rd_req,
  input  logic [SW-1:0]      rd_sel,
  output logic               rd_ack,
  output logic [CW-1:0]      rd_data,
  output logic               rd_sat,
  output logic [TW-1:0]      total,
  output logic               total_sat
);

  // Per-transition increment width: wide enough for a weight or FALL_W.
  localparam int FALL_BW = $clog2(FALL_W + 1) + 1;
  localparam int DW      = (WW > FALL_BW) ? WW : FALL_BW;
  // Channel and total sums carry an extra bit so an overflow is visible
  // before clamping instead of wrapping.
  localparam int CSW     = ((CW > DW) ? CW : DW) + 1;
  localparam int TDW     = DW + $clog2(N_CH) + 1;
  localparam int TSW     = ((TW > TDW) ? TW : TDW) + 1;

  localparam logic [CSW-1:0] CNT_MAX = {{(CSW-CW){1'b0}}, {CW{1'b1}}};
  localparam logic [TSW-1:0] TOT_MAX = {{(TSW-TW){1'b0}}, {TW{1'b1}}};

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_t;

  logic [N_CH-1:0] prev_r;
  logic [N_CH-1:0] rise_s;
`ifdef PWR_FALL_EDGE_EN
  logic [N_CH-1:0] fall_s;
`endif
  logic [DW-1:0]   delta_s     [N_CH];
  logic [CSW-1:0]  cnt_sum_s   [N_CH];
  logic [CW-1:0]   cnt_r       [N_CH];
  logic [CW-1:0]   cnt_nxt_s   [N_CH];
  logic [N_CH-1:0] sat_r;
  logic [N_CH-1:0] sat_nxt_s;
  logic [TDW-1:0]  tot_delta_s;
  logic [TSW-1:0]  tot_sum_s;
  logic [TW-1:0]   total_r;
  logic [TW-1:0]   total_nxt_s;
  logic            total_sat_r;
  logic            total_sat_nxt_s;

  rd_state_t       rd_state_r;
  rd_state_t       rd_state_nxt_s;
  logic [CW-1:0]   sel_cnt_s;
  logic            sel_sat_s;
  logic            rd_ack_r;
  logic            rd_ack_nxt_s;
  logic [CW-1:0]   rd_data_r;
  logic [CW-1:0]   rd_data_nxt_s;
  logic            rd_sat_r;
  logic            rd_sat_nxt_s;

  assign rise_s = sig_in & ~prev_r;
`ifdef PWR_FALL_EDGE_EN
  assign fall_s = ~sig_in & prev_r;
`endif

  // Per-channel increment for this cycle; a zero weight masks the channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      delta_s[i] = {DW{1'b0}};
      if (rise_s[i]) begin
        delta_s[i] = DW'(weight_in[i*WW +: WW]);
      end
`ifdef PWR_FALL_EDGE_EN
      else if (fall_s[i] && (weight_in[i*WW +: WW] != {WW{1'b0}})) begin
        delta_s[i] = DW'(FALL_W);
      end
`endif
      else begin
        delta_s[i] = {DW{1'b0}};
      end
    end
  end

  // Full-width sums, then clamp to the accumulator maxima and flag overflow.
  always_comb begin
    tot_delta_s = {TDW{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      cnt_sum_s[i] = CSW'(cnt_r[i]) + CSW'(delta_s[i]);
      if (cnt_sum_s[i] > CNT_MAX) begin
        cnt_nxt_s[i] = {CW{1'b1}};
        sat_nxt_s[i] = 1'b1;
      end else begin
        cnt_nxt_s[i] = cnt_sum_s[i][CW-1:0];
        sat_nxt_s[i] = sat_r[i];
      end
      tot_delta_s = tot_delta_s + TDW'(delta_s[i]);
    end
    tot_sum_s = TSW'(total_r) + TSW'(tot_delta_s);
    if (tot_sum_s > TOT_MAX) begin
      total_nxt_s     = {TW{1'b1}};
      total_sat_nxt_s = 1'b1;
    end else begin
      total_nxt_s     = tot_sum_s[TW-1:0];
      total_sat_nxt_s = total_sat_r;
    end
  end

  // Edge history always follows the input, including through reset and clr.
  always_ff @(posedge clk) begin
    prev_r <= sig_in;
  end

  // Accumulator state: reset beats clr beats accumulate; enable=0 freezes.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
      sat_r       <= {N_CH{1'b0}};
      total_r     <= {TW{1'b0}};
      total_sat_r <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      sat_r       <= sat_nxt_s;
      total_r     <= total_nxt_s;
      total_sat_r <= total_sat_nxt_s;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= cnt_r[i];
      end
      sat_r       <= sat_r;
      total_r     <= total_r;
      total_sat_r <= total_sat_r;
    end
  end

  // Read-select mux; an index with no matching channel reads as zero.
  always_comb begin
    sel_cnt_s = {CW{1'b0}};
    sel_sat_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      sel_cnt_s = (rd_sel == SW'(i)) ? cnt_r[i] : sel_cnt_s;
      sel_sat_s = (rd_sel == SW'(i)) ? sat_r[i] : sel_sat_s;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_r <= RD_IDLE;
    end else begin
      rd_state_r <= rd_state_nxt_s;
    end
  end

  // Read FSM next state: one capture per rising request.
  always_comb begin
    rd_state_nxt_s = RD_IDLE;
    case (rd_state_r)
      RD_IDLE: begin
        if (rd_req) begin
          rd_state_nxt_s = RD_ACK;
        end else begin
          rd_state_nxt_s = RD_IDLE;
        end
      end
      RD_ACK: begin
        if (rd_req) begin
          rd_state_nxt_s = RD_ACK;
        end else begin
          rd_state_nxt_s = RD_IDLE;
        end
      end
      default: rd_state_nxt_s = RD_IDLE;
    endcase
  end

  // Read FSM outputs: snapshot on acceptance, hold while acknowledged.
  always_comb begin
    rd_ack_nxt_s  = 1'b0;
    rd_data_nxt_s = rd_data_r;
    rd_sat_nxt_s  = rd_sat_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (rd_req) begin
          rd_ack_nxt_s  = 1'b1;
          rd_data_nxt_s = sel_cnt_s;
          rd_sat_nxt_s  = sel_sat_s;
        end else begin
          rd_ack_nxt_s  = 1'b0;
        end
      end
      RD_ACK: begin
        if (rd_req) begin
          rd_ack_nxt_s = 1'b1;
        end else begin
          rd_ack_nxt_s = 1'b0;
        end
      end
      default: rd_ack_nxt_s = 1'b0;
    endcase
  end

  // Registered read outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack_r  <= 1'b0;
      rd_data_r <= {CW{1'b0}};
      rd_sat_r  <= 1'b0;
    end else begin
      rd_ack_r  <= rd_ack_nxt_s;
      rd_data_r <= rd_data_nxt_s;
      rd_sat_r  <= rd_sat_nxt_s;
    end
  end

  assign rd_ack    = rd_ack_r;
  assign rd_data   = rd_data_r;
  assign rd_sat    = rd_sat_r;
  assign total     = total_r;
  assign total_sat = total_sat_r;

endmodule

// File: tb/tb_pwr_trans_acc.sv
// Directed self-checking bench for pwr_trans_acc (default parameters).
// Expected values are hand-derived; FE adds the fall-edge contribution
// when the design is built with PWR_FALL_EDGE_EN (FALL_W = 1).
module tb_pwr_trans_acc;

  localparam int N_CH = 4;
  localparam int WW   = 4;
  localparam int CW   = 8;
  localparam int TW   = 12;
  localparam int SW   = 2;
`ifdef PWR_FALL_EDGE_EN
  localparam int FE = 1;
`else
  localparam int FE = 0;
`endif

  logic               clk;
  logic               reset;
  logic               enable;
  logic               clr;
  logic [N_CH-1:0]    sig_in;
  logic [N_CH*WW-1:0] weight_in;
  logic               rd_req;
  logic [SW-1:0]      rd_sel;
  logic               rd_ack;
  logic [CW-1:0]      rd_data;
  logic               rd_sat;
  logic [TW-1:0]      total;
  logic               total_sat;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [CW-1:0] rd_d;
  logic          rd_s;
  logic          rd_ok;
  logic [TW-1:0] exp_t;
  logic [CW-1:0] exp_c;
  int            sum_i;

  pwr_trans_acc #(
    .N_CH(N_CH), .WW(WW), .CW(CW), .TW(TW), .SW(SW), .FALL_W(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr),
    .sig_in(sig_in), .weight_in(weight_in),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_sat(rd_sat),
    .total(total), .total_sat(total_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int ch, input int w);
    weight_in[ch*WW +: WW] = w[WW-1:0];
  endtask

  task automatic pulse(input int ch);
    sig_in[ch] = 1'b1;
    tick();
    sig_in[ch] = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Full handshake on channel ch; waits at most 4 cycles for rd_ack.
  task automatic do_read(input int ch, output logic [CW-1:0] d,
                         output logic s, output logic ok);
    rd_sel = ch[SW-1:0];
    rd_req = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 4 && !ok; k++) begin
      tick();
      if (rd_ack === 1'b1) ok = 1'b1;
    end
    d = rd_data;
    s = rd_sat;
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clr = 1'b0; rd_req = 1'b0; rd_sel = '0;
    sig_in = 4'b1111; weight_in = 16'h42F5;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    vec_cnt++;
    if (total !== 12'd0) begin err_cnt++; $display("FAIL reset_total: got %0d expected 0", total); end
    vec_cnt++;
    if (total_sat !== 1'b0) begin err_cnt++; $display("FAIL reset_total_sat: got %b expected 0", total_sat); end
    vec_cnt++;
    if (rd_ack !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_ack: got %b expected 0", rd_ack); end
    for (int c = 0; c < N_CH; c++) begin
      do_read(c, rd_d, rd_s, rd_ok);
      vec_cnt++;
      if (rd_ok !== 1'b1 || rd_d !== 8'd0 || rd_s !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_cnt%0d: got ack=%b data=%0d sat=%b expected ack=1 data=0 sat=0", c, rd_ok, rd_d, rd_s);
      end
    end
    weight_in = 16'h0000;
    sig_in = 4'b0000;
    tick();
    weight_in = 16'h42F5;
  endtask

  task automatic test_basic();
    repeat (3) pulse(0);
    exp_t = TW'(15 + 3*FE);
    vec_cnt++;
    if (total !== exp_t) begin err_cnt++; $display("FAIL basic_total: got %0d expected %0d", total, exp_t); end
    rd_sel = 2'd0; rd_req = 1'b1;
    tick();
    exp_c = CW'(15 + 3*FE);
    vec_cnt++;
    if (rd_ack !== 1'b1 || rd_data !== exp_c || rd_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_read: got ack=%b data=%0d sat=%b expected ack=1 data=%0d sat=0", rd_ack, rd_data, rd_sat, exp_c);
    end
    tick();
    vec_cnt++;
    if (rd_ack !== 1'b1) begin err_cnt++; $display("FAIL basic_ack_hold: got %b expected 1", rd_ack); end
    do_clear();
    vec_cnt++;
    if (rd_ack !== 1'b1 || rd_data !== exp_c) begin
      err_cnt++;
      $display("FAIL clr_in_ack: got ack=%b data=%0d expected ack=1 data=%0d", rd_ack, rd_data, exp_c);
    end
    vec_cnt++;
    if (total !== 12'd0) begin err_cnt++; $display("FAIL clr_total: got %0d expected 0", total); end
    rd_req = 1'b0;
    tick();
    vec_cnt++;
    if (rd_ack !== 1'b0) begin err_cnt++; $display("FAIL basic_ack_drop: got %b expected 0", rd_ack); end
  endtask

  task automatic test_saturate();
    do_clear();
    repeat (20) pulse(1);
    do_read(1, rd_d, rd_s, rd_ok);
    vec_cnt++;
    if (rd_ok !== 1'b1 || rd_d !== 8'd255 || rd_s !== 1'b1) begin
      err_cnt++;
      $display("FAIL sat_ch1: got ack=%b data=%0d sat=%b expected ack=1 data=255 sat=1", rd_ok, rd_d, rd_s);
    end
    exp_t = TW'(300 + 20*FE);
    vec_cnt++;
    if (total !== exp_t || total_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL sat_total: got %0d/%b expected %0d/0", total, total_sat, exp_t);
    end
  endtask

  task automatic test_total_sat();
    do_clear();
    weight_in = 16'hFFFF;
    repeat (68) begin
      sig_in = 4'b1111; tick();
      sig_in = 4'b0000; tick();
    end
    sum_i = 68 * (60 + 4*FE);
    exp_t = (sum_i > 4095) ? 12'hFFF : TW'(sum_i);
    vec_cnt++;
    if (total !== exp_t || total_sat !== (sum_i > 4095)) begin
      err_cnt++;
      $display("FAIL tot_below: got %0d/%b expected %0d/%b", total, total_sat, exp_t, (sum_i > 4095));
    end
    sig_in = 4'b1111; tick();
    sig_in = 4'b0000; tick();
    vec_cnt++;
    if (total !== 12'hFFF || total_sat !== 1'b1) begin
      err_cnt++;
      $display("FAIL tot_sat: got %0d/%b expected 4095/1", total, total_sat);
    end
    do_clear();
    vec_cnt++;
    if (total !== 12'd0 || total_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL tot_clr: got %0d/%b expected 0/0", total, total_sat);
    end
    weight_in = 16'h42F5;
  endtask

  task automatic test_enable();
    do_clear();
    enable = 1'b0;
    pulse(0); pulse(0);
    sig_in[0] = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    vec_cnt++;
    if (total !== 12'd0) begin err_cnt++; $display("FAIL enable_freeze: got %0d expected 0", total); end
    sig_in[0] = 1'b0;
    tick();
    exp_t = TW'(FE);
    vec_cnt++;
    if (total !== exp_t) begin err_cnt++; $display("FAIL enable_resume: got %0d expected %0d", total, exp_t); end
  endtask

  task automatic test_snapshot();
    do_clear();
    set_w(2, 7);
    sig_in[2] = 1'b1; tick();
    set_w(2, 0);
    sig_in[2] = 1'b0; tick();
    set_w(2, 2);
    sig_in[2] = 1'b1; rd_sel = 2'd2; rd_req = 1'b1;
    tick();
    vec_cnt++;
    if (rd_ack !== 1'b1 || rd_data !== 8'd7) begin
      err_cnt++;
      $display("FAIL snap_pre: got ack=%b data=%0d expected ack=1 data=7", rd_ack, rd_data);
    end
    rd_req = 1'b0;
    tick();
    do_read(2, rd_d, rd_s, rd_ok);
    vec_cnt++;
    if (rd_ok !== 1'b1 || rd_d !== 8'd9) begin
      err_cnt++;
      $display("FAIL snap_post: got ack=%b data=%0d expected ack=1 data=9", rd_ok, rd_d);
    end
    set_w(2, 0);
    sig_in[2] = 1'b0; tick();
    set_w(2, 2);
  endtask

  task automatic test_clr_collision();
    repeat (18) pulse(1);
    do_read(1, rd_d, rd_s, rd_ok);
    vec_cnt++;
    if (rd_s !== 1'b1) begin err_cnt++; $display("FAIL clr_pre_sat: got %b expected 1", rd_s); end
    sig_in[3] = 1'b1;
    do_clear();
    vec_cnt++;
    if (total !== 12'd0 || total_sat !== 1'b0) begin
      err_cnt++;
      $display("FAIL clr_edge_total: got %0d/%b expected 0/0", total, total_sat);
    end
    do_read(3, rd_d, rd_s, rd_ok);
    vec_cnt++;
    if (rd_ok !== 1'b1 || rd_d !== 8'd0) begin
      err_cnt++;
      $display("FAIL clr_edge_ch3: got ack=%b data=%0d expected ack=1 data=0", rd_ok, rd_d);
    end
    do_read(1, rd_d, rd_s, rd_ok);
    vec_cnt++;
    if (rd_d !== 8'd0 || rd_s !== 1'b0) begin
      err_cnt++;
      $display("FAIL clr_ch1: got data=%0d sat=%b expected data=0 sat=0", rd_d, rd_s);
    end
    set_w(3, 0);
    sig_in[3] = 1'b0; tick();
    set_w(3, 4);
    sig_in[3] = 1'b1; tick();
    do_read(3, rd_d, rd_s, rd_ok);
    vec_cnt++;
    if (rd_d !== 8'd4 || total !== 12'd4) begin
      err_cnt++;
      $display("FAIL clr_next_rise: got cnt=%0d total=%0d expected cnt=4 total=4", rd_d, total);
    end
    set_w(3, 0);
    sig_in[3] = 1'b0; tick();
    set_w(3, 4);
  endtask

  task automatic test_fall();
    do_clear();
    set_w(0, 3);
    pulse(0); pulse(0);
    do_read(0, rd_d, rd_s, rd_ok);
    exp_c = CW'(6 + 2*FE);
    vec_cnt++;
    if (rd_ok !== 1'b1 || rd_d !== exp_c) begin
      err_cnt++;
      $display("FAIL fall_ch0: got ack=%b data=%0d expected ack=1 data=%0d", rd_ok, rd_d, exp_c);
    end
  endtask

  task automatic test_reset_in_ack();
    rd_sel = 2'd0; rd_req = 1'b1;
    tick();
    vec_cnt++;
    if (rd_ack !== 1'b1) begin err_cnt++; $display("FAIL rst_ack_pre: got %b expected 1", rd_ack); end
    reset = 1'b1;
    tick();
    reset = 1'b0; rd_req = 1'b0;
    vec_cnt++;
    if (rd_ack !== 1'b0 || rd_data !== 8'd0 || total !== 12'd0) begin
      err_cnt++;
      $display("FAIL rst_in_ack: got ack=%b data=%0d total=%0d expected 0/0/0", rd_ack, rd_data, total);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_total_sat();
    test_enable();
    test_snapshot();
    test_clr_collision();
    test_fall();
    test_reset_in_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
